// File: rtl/pattern_scan_ctrl_if.sv
// Handshake/config bundle between a byte source, the scan controller and its
// consumer. The master drives configuration, control and upstream bytes; the
// slave (the controller) returns the handshake and match status.
interface pattern_scan_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
);
  logic                cfg_we;
  logic [PAT_MAX-1:0]  cfg_pattern;
  logic [LEN_W-1:0]    cfg_len;
  logic [CNT_W-1:0]    cfg_thresh;
  logic                start;
  logic                stop;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic                busy;
  logic                match_pulse;
  logic [CNT_W-1:0]    match_count;
  logic                thresh_hit;
  logic                cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_thresh, start, stop, in_valid, in_data,
    input  in_ready, busy, match_pulse, match_count, thresh_hit, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_thresh, start, stop, in_valid, in_data,
    output in_ready, busy, match_pulse, match_count, thresh_hit, cfg_err
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Runtime-programmable bit-pattern scanner. Bytes are accepted one at a time,
// serialised MSB-first into a history register, and every shift is compared
// against the low len bits of the programmed pattern. Overlapping matches are
// counted; reaching a non-zero threshold ends the scan.
module pattern_scan_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  pattern_scan_ctrl_if.slave  bus
);
  localparam int LEN_W = $clog2(PAT_MAX + 1);
  localparam int BL_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [PAT_MAX-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    thresh_q, thresh_d;
  logic [PAT_MAX-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]    bits_seen_q, bits_seen_d;
  logic [BL_W-1:0]     bits_left_q, bits_left_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                match_pulse_q, match_pulse_d;
  logic [CNT_W-1:0]    match_count_q, match_count_d;
  logic                thresh_hit_q, thresh_hit_d;
  logic                cfg_err_q, cfg_err_d;

  logic                shift_en, accept, cfg_take, start_req, len_valid;
  logic [PAT_MAX-1:0]  hist_shift, len_mask;
  logic [LEN_W-1:0]    seen_shift;
  logic [CNT_W-1:0]    count_inc;
  logic                match, thresh_reached;

  // Mask selecting the low len_q bits of history and pattern.
  for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_q);
  end

  // A stop in SCAN pre-empts both shifting and accepting on that edge.
  assign shift_en   = (state_q == ST_SCAN) && !bus.stop && (bits_left_q != '0);
  assign accept     = (state_q == ST_SCAN) && !bus.stop && (bits_left_q == '0) && bus.in_valid;
  assign cfg_take   = (state_q != ST_SCAN) && bus.cfg_we;
  assign start_req  = (state_q != ST_SCAN) && !bus.cfg_we && bus.start && !bus.stop;
  assign len_valid  = (len_q != '0) && (len_q <= LEN_W'(PAT_MAX));

  assign hist_shift = {hist_q[PAT_MAX-2:0], buf_q[DATA_W-1]};
  assign seen_shift = (bits_seen_q == LEN_W'(PAT_MAX)) ? bits_seen_q : bits_seen_q + LEN_W'(1);
  assign match      = shift_en && (((hist_shift ^ pat_q) & len_mask) == '0) && (seen_shift >= len_q);
  assign count_inc  = (match_count_q == '1) ? match_count_q : match_count_q + CNT_W'(1);
  assign thresh_reached = match && (thresh_q != '0) && (count_inc == thresh_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: stop aborts a scan, threshold ends it, config/start act outside it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN: begin
        if (bus.stop)           state_d = ST_IDLE;
        else if (thresh_reached) state_d = ST_DONE;
      end
      default: begin
        if (bus.cfg_we)                   state_d = ST_IDLE;
        else if (start_req && len_valid)  state_d = ST_SCAN;
      end
    endcase
  end

  // State-decoded outputs; in_ready depends only on registers.
  always_comb begin
    bus.busy     = (state_q == ST_SCAN);
    bus.in_ready = (state_q == ST_SCAN) && (bits_left_q == '0);
  end

  // Datapath next values: config latch, scan clear, byte load and bit shift.
  always_comb begin
    pat_d         = pat_q;
    len_d         = len_q;
    thresh_d      = thresh_q;
    hist_d        = hist_q;
    bits_seen_d   = bits_seen_q;
    bits_left_d   = bits_left_q;
    buf_d         = buf_q;
    match_pulse_d = match;
    match_count_d = match_count_q;
    thresh_hit_d  = thresh_hit_q;
    cfg_err_d     = cfg_err_q;
    if (cfg_take) begin
      pat_d     = bus.cfg_pattern;
      len_d     = bus.cfg_len;
      thresh_d  = bus.cfg_thresh;
      cfg_err_d = 1'b0;
    end
    if (start_req) begin
      if (len_valid) begin
        hist_d        = '0;
        bits_seen_d   = '0;
        bits_left_d   = '0;
        match_count_d = '0;
        thresh_hit_d  = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    if (state_q == ST_SCAN) begin
      if (bus.stop) begin
        bits_left_d = '0;
      end else if (shift_en) begin
        buf_d       = {buf_q[DATA_W-2:0], 1'b0};
        bits_left_d = bits_left_q - BL_W'(1);
        hist_d      = hist_shift;
        bits_seen_d = seen_shift;
        if (match) match_count_d = count_inc;
        if (thresh_reached) begin
          thresh_hit_d = 1'b1;
          bits_left_d  = '0;
        end
      end else if (accept) begin
        buf_d       = bus.in_data;
        bits_left_d = BL_W'(DATA_W);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q         <= '0;
      len_q         <= '0;
      thresh_q      <= '0;
      hist_q        <= '0;
      bits_seen_q   <= '0;
      bits_left_q   <= '0;
      buf_q         <= '0;
      match_pulse_q <= 1'b0;
      match_count_q <= '0;
      thresh_hit_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      pat_q         <= pat_d;
      len_q         <= len_d;
      thresh_q      <= thresh_d;
      hist_q        <= hist_d;
      bits_seen_q   <= bits_seen_d;
      bits_left_q   <= bits_left_d;
      buf_q         <= buf_d;
      match_pulse_q <= match_pulse_d;
      match_count_q <= match_count_d;
      thresh_hit_q  <= thresh_hit_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign bus.match_pulse = match_pulse_q;
  assign bus.match_count = match_count_q;
  assign bus.thresh_hit  = thresh_hit_q;
  assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed and randomized bench for pattern_scan_ctrl. A queue-based reference
// model tracks pending bits and the whole bit stream of the current scan and
// predicts every output after every clock edge.
module tb_pattern_scan_ctrl;
  localparam int DATA_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(PAT_MAX + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.DATA_W(DATA_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) bus ();

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: 0 idle, 1 scan, 2 done.
  int         m_state;
  logic [7:0] m_pat;
  int         m_len, m_thresh, m_count;
  bit         m_hit, m_err, m_pulse, m_accepted;
  int         m_pend[$];
  int         m_stream[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Last m_len stream bits (newest first) equal pattern bits 0..m_len-1.
  function automatic bit pattern_hit();
    int n;
    n = m_stream.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_stream[n-1-i] != int'(m_pat[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int b;
    m_accepted = 1'b0;
    m_pulse    = 1'b0;
    if (reset) begin
      m_state = 0; m_pat = '0; m_len = 0; m_thresh = 0; m_count = 0;
      m_hit = 1'b0; m_err = 1'b0;
      m_pend.delete(); m_stream.delete();
    end else if (m_state == 1) begin
      if (bus.stop) begin
        m_state = 0;
        m_pend.delete();
      end else if (m_pend.size() > 0) begin
        b = m_pend.pop_front();
        m_stream.push_back(b);
        if (pattern_hit()) begin
          if (m_count < 255) m_count++;
          m_pulse = 1'b1;
          if (m_thresh != 0 && m_count == m_thresh) begin
            m_hit = 1'b1;
            m_state = 2;
            m_pend.delete();
          end
        end
      end else if (bus.in_valid) begin
        m_accepted = 1'b1;
        for (int i = DATA_W - 1; i >= 0; i--) m_pend.push_back(int'(bus.in_data[i]));
      end
    end else begin
      if (bus.cfg_we) begin
        m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len); m_thresh = int'(bus.cfg_thresh);
        m_err = 1'b0; m_state = 0;
      end else if (bus.start && !bus.stop) begin
        if (m_len >= 1 && m_len <= PAT_MAX) begin
          m_state = 1; m_count = 0; m_hit = 1'b0;
          m_stream.delete(); m_pend.delete();
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  // One clock: advance model at the edge, compare 1 time unit later, drop strobes.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_eq("in_ready",    bus.in_ready,    32'(m_state == 1 && m_pend.size() == 0));
    check_eq("busy",        bus.busy,        32'(m_state == 1));
    check_eq("match_pulse", bus.match_pulse, 32'(m_pulse));
    check_eq("match_count", bus.match_count, 32'(m_count));
    check_eq("thresh_hit",  bus.thresh_hit,  32'(m_hit));
    check_eq("cfg_err",     bus.cfg_err,     32'(m_err));
    bus.cfg_we = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    if (m_accepted) bus.in_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic cfg(input logic [7:0] p, input int l, input int t);
    bus.cfg_we = 1'b1; bus.cfg_pattern = p; bus.cfg_len = LEN_W'(l); bus.cfg_thresh = CNT_W'(t);
    cyc();
  endtask

  task automatic go();
    bus.start = 1'b1;
    cyc();
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Present a byte and hold it until accepted (bounded); returns right after the accept edge.
  task automatic send(input logic [7:0] b);
    int k;
    bus.in_valid = 1'b1; bus.in_data = b;
    k = 0;
    while (bus.in_valid && m_state == 1 && k < 40) begin
      cyc();
      k++;
    end
    if (bus.in_valid) begin
      if (m_state == 1) check_eq("accept_timeout", bus.in_ready, 32'd1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_state == 1 && m_pend.size() > 0 && k < 20) begin
      cyc();
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, gap;
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_thresh = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    run(2);
    reset = 1'b0;
    check_eq("rst_busy", bus.busy, 32'd0);
    check_eq("rst_count", bus.match_count, 32'd0);

    // "110" on 0xDB: pulses after shift edges 3 and 6, ready back after edge 8.
    cfg(8'h06, 3, 0);
    go();
    send(8'hDB);
    run(3);
    check_eq("t1_pulse_e3", bus.match_pulse, 32'd1);
    run(3);
    check_eq("t1_pulse_e6", bus.match_pulse, 32'd1);
    run(1);
    check_eq("t1_ready_e7", bus.in_ready, 32'd0);
    run(1);
    check_eq("t1_ready_e8", bus.in_ready, 32'd1);
    check_eq("t1_count", bus.match_count, 32'd2);
    halt();

    // "1111" on 0xFF 0xFF: matches span the byte boundary.
    cfg(8'h0F, 4, 0);
    go();
    send(8'hFF);
    send(8'hFF);
    drain();
    check_eq("t2_count", bus.match_count, 32'd13);
    halt();

    // "1" with threshold 3 on 0xE0: done after the third bit.
    cfg(8'h01, 1, 3);
    go();
    send(8'hE0);
    run(3);
    check_eq("t3_hit", bus.thresh_hit, 32'd1);
    check_eq("t3_busy", bus.busy, 32'd0);
    check_eq("t3_ready", bus.in_ready, 32'd0);
    run(5);
    check_eq("t3_count", bus.match_count, 32'd3);

    // Invalid lengths 0 and 9, then recovery.
    cfg(8'h00, 0, 0);
    go();
    check_eq("t4_err_len0", bus.cfg_err, 32'd1);
    cfg(8'h00, 9, 0);
    check_eq("t4_err_clr", bus.cfg_err, 32'd0);
    go();
    check_eq("t4_err_len9", bus.cfg_err, 32'd1);
    cfg(8'h06, 3, 0);
    check_eq("t4_err_clr2", bus.cfg_err, 32'd0);
    go();
    check_eq("t4_busy", bus.busy, 32'd1);
    halt();

    // "11" on 0xFF, stop after third shift; restart clears count and history.
    cfg(8'h03, 2, 0);
    go();
    send(8'hFF);
    run(3);
    halt();
    check_eq("t5_stop_count", bus.match_count, 32'd2);
    check_eq("t5_stop_busy", bus.busy, 32'd0);
    go();
    check_eq("t5_restart_count", bus.match_count, 32'd0);
    send(8'h40);
    drain();
    check_eq("t5_after40", bus.match_count, 32'd0);

    // Reset mid-byte with count 2; length also returns to 0.
    send(8'hFF);
    run(3);
    check_eq("t6_pre_count", bus.match_count, 32'd2);
    do_reset();
    check_eq("t6_busy", bus.busy, 32'd0);
    check_eq("t6_count", bus.match_count, 32'd0);
    go();
    check_eq("t6_err", bus.cfg_err, 32'd1);

    // Randomized scenarios checked every cycle by the model.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      cfg(8'($urandom), (($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : $urandom_range(1, 8)),
          (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5)));
      if ($urandom_range(0, 5) == 0) begin
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc();
      end
      go();
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        if (m_state != 1) break;
        gap = $urandom_range(0, 3);
        run(gap);
        if ($urandom_range(0, 4) == 0) cfg(8'($urandom), $urandom_range(1, 8), $urandom_range(0, 3));
        send((($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom)));
        if ($urandom_range(0, 7) == 0) begin
          run($urandom_range(0, 7));
          if ($urandom_range(0, 1) == 0) halt();
          else do_reset();
        end
      end
      run($urandom_range(2, 10));
      if (m_state == 1) halt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
